// File: rtl/isa_sizer_pkg.sv
// Shared types and defaults for the ISA-side cycle sequencer.
package isa_sizer_pkg;

  localparam int unsigned DEF_ADDR_CYCLES = 2;
  localparam int unsigned DEF_CMD_CYCLES  = 4;
  localparam int unsigned DEF_RECOVERY    = 2;
  localparam int unsigned DEF_TIMEOUT     = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_CMD,
    ST_WAITRDY,
    ST_RECOV,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    PLAN_WORD,
    PLAN_BYTE_PAIR,
    PLAN_BYTE_SINGLE
  } plan_e;

  // Bus sizing: a full word goes out as one 16-bit cycle only if the target claims CS16.
  function automatic plan_e plan_select(input logic uds_n, input logic lds_n, input logic cs16_n);
    if (!uds_n && !lds_n) return cs16_n ? PLAN_BYTE_PAIR : PLAN_WORD;
    return PLAN_BYTE_SINGLE;
  endfunction

endpackage

// File: rtl/isa_phase_counter.sv
// Loadable down-counter; terminal_c flags the last cycle of the current phase.
module isa_phase_counter #(
  parameter int unsigned W = 8
) (
  input  logic         mclk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         terminal_c
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset)              cnt_q <= '0;
    else if (load)           cnt_q <= load_value;
    else if (cnt_q != '0)    cnt_q <= cnt_q - W'(1);
  end

  assign terminal_c = (cnt_q == '0);

endmodule

// File: rtl/isa_bus_sizer.sv
// Runs one or two 8/16-bit ISA cycles per decoded Amiga access, with CS16 sizing,
// IOCHRDY wait extension and a ready timeout. Outputs are registered from the current state.
module isa_bus_sizer
  import isa_sizer_pkg::*;
#(
  parameter int unsigned ADDR_CYCLES = DEF_ADDR_CYCLES,
  parameter int unsigned CMD_CYCLES  = DEF_CMD_CYCLES,
  parameter int unsigned RECOVERY    = DEF_RECOVERY,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic        req,
  input  logic        rw,
  input  logic        is_io,
  input  logic        uds_n,
  input  logic        lds_n,
  input  logic [15:0] wdata,
  input  logic        cs16_n,
  input  logic        iochrdy,
  input  logic [15:0] dg_in,
  output logic [15:0] dg_out,
  output logic        dg_oe,
  output logic        sa0,
  output logic        sbhe_n,
  output logic        bale_n,
  output logic        ior_n,
  output logic        iow_n,
  output logic        memr_n,
  output logic        memw_n,
  output logic [15:0] rdata,
  output logic        ack,
  output logic        err
);

  localparam int unsigned MAX_AC   = (ADDR_CYCLES > CMD_CYCLES) ? ADDR_CYCLES : CMD_CYCLES;
  localparam int unsigned MAX_RT   = (RECOVERY > TIMEOUT) ? RECOVERY : TIMEOUT;
  localparam int unsigned MAX_LOAD = (MAX_AC > MAX_RT) ? MAX_AC : MAX_RT;
  localparam int unsigned CNT_W    = (MAX_LOAD > 1) ? $clog2(MAX_LOAD) : 1;

  state_e state_q, state_d;
  plan_e  plan_q, plan_c, cur_plan;
  logic   rw_q, is_io_q, phase_q, uds_sel_q, cur_uds_n;
  logic [15:0] wdata_q, rdata_next_c;
  logic   cnt_load, cnt_term_c;
  logic [CNT_W-1:0] cnt_load_value;
  logic   pending_c, addr_end_c, timeout_c, strobe_low_c, cmd_next_c, capture_c;

  logic [15:0] dg_out_d;
  logic dg_oe_d, sa0_d, sbhe_n_d, bale_n_d, ior_n_d, iow_n_d, memr_n_d, memw_n_d, ack_d;

  isa_phase_counter #(.W(CNT_W)) u_phase_counter (
    .mclk       (mclk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .terminal_c (cnt_term_c)
  );

  assign plan_c       = plan_select(uds_n, lds_n, cs16_n);
  assign pending_c    = (plan_q == PLAN_BYTE_PAIR) && !phase_q;
  assign addr_end_c   = (state_q == ST_ADDR) && cnt_term_c;
  assign timeout_c    = (state_q == ST_WAITRDY) && !iochrdy && cnt_term_c;
  assign strobe_low_c = !(ior_n && iow_n && memr_n && memw_n);
  assign cmd_next_c   = (state_q == ST_CMD) || (state_q == ST_WAITRDY);
  assign capture_c    = rw_q && strobe_low_c && !cmd_next_c;

  // State register
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (req) state_d = ST_ADDR;
      ST_ADDR:    if (cnt_term_c) state_d = ST_CMD;
      ST_CMD:     if (cnt_term_c) state_d = iochrdy ? ST_RECOV : ST_WAITRDY;
      ST_WAITRDY: if (iochrdy || cnt_term_c) state_d = ST_RECOV;
      ST_RECOV: begin
        if (cnt_term_c) begin
          if (pending_c && req) state_d = ST_ADDR;
          else if (req)         state_d = ST_DONE;
          else                  state_d = ST_IDLE;
        end
      end
      ST_DONE:    if (!req) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Phase length reload on every state entry
  always_comb begin
    cnt_load       = (state_d != state_q);
    cnt_load_value = '0;
    unique case (state_d)
      ST_ADDR:    cnt_load_value = CNT_W'(ADDR_CYCLES - 1);
      ST_CMD:     cnt_load_value = CNT_W'(CMD_CYCLES - 1);
      ST_WAITRDY: cnt_load_value = CNT_W'(TIMEOUT - 1);
      ST_RECOV:   cnt_load_value = CNT_W'(RECOVERY - 1);
      default:    cnt_load_value = '0;
    endcase
  end

  // Read assembly: Amiga even byte (D15:8) is ISA sa0 = 0
  always_comb begin
    rdata_next_c = dg_in;
    unique case (plan_q)
      PLAN_WORD:        rdata_next_c = dg_in;
      PLAN_BYTE_PAIR:   rdata_next_c = phase_q ? {rdata[15:8], dg_in[7:0]} : {dg_in[7:0], rdata[7:0]};
      PLAN_BYTE_SINGLE: rdata_next_c = uds_sel_q ? {8'hFF, dg_in[7:0]} : {dg_in[7:0], 8'hFF};
      default:          rdata_next_c = dg_in;
    endcase
  end

  // Access context, plan latch, read data and sticky timeout flag
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      rw_q      <= 1'b0;
      is_io_q   <= 1'b0;
      phase_q   <= 1'b0;
      plan_q    <= PLAN_WORD;
      uds_sel_q <= 1'b1;
      wdata_q   <= '0;
      rdata     <= '0;
      err       <= 1'b0;
    end else begin
      if ((state_q == ST_IDLE) && req) begin
        rw_q    <= rw;
        is_io_q <= is_io;
        phase_q <= 1'b0;
        err     <= 1'b0;
      end
      if (addr_end_c) begin
        wdata_q <= wdata;
        if (!phase_q) begin
          plan_q    <= plan_c;
          uds_sel_q <= uds_n;
        end
      end
      if ((state_q == ST_RECOV) && (state_d == ST_ADDR)) phase_q <= 1'b1;
      if (timeout_c) err <= 1'b1;
      if (capture_c) rdata <= rdata_next_c;
    end
  end

  // Output decode; during the first ADDR phase the plan is not latched yet, so use live strobes
  always_comb begin
    dg_out_d  = '0;
    dg_oe_d   = 1'b0;
    sa0_d     = 1'b0;
    sbhe_n_d  = 1'b1;
    bale_n_d  = 1'b1;
    ior_n_d   = 1'b1;
    iow_n_d   = 1'b1;
    memr_n_d  = 1'b1;
    memw_n_d  = 1'b1;
    ack_d     = (state_q == ST_DONE);
    cur_plan  = ((state_q == ST_ADDR) && !phase_q) ? plan_c : plan_q;
    cur_uds_n = ((state_q == ST_ADDR) && !phase_q) ? uds_n : uds_sel_q;

    if ((state_q == ST_ADDR) || cmd_next_c || (state_q == ST_RECOV)) begin
      unique case (cur_plan)
        PLAN_WORD:        begin sa0_d = 1'b0;      sbhe_n_d = 1'b0; end
        PLAN_BYTE_PAIR:   begin sa0_d = phase_q;   sbhe_n_d = 1'b1; end
        PLAN_BYTE_SINGLE: begin sa0_d = cur_uds_n; sbhe_n_d = 1'b1; end
        default:          begin sa0_d = 1'b0;      sbhe_n_d = 1'b1; end
      endcase
    end

    if ((state_q == ST_ADDR) || cmd_next_c) bale_n_d = 1'b0;

    if (!rw_q && (cmd_next_c || (state_q == ST_RECOV))) begin
      dg_oe_d  = 1'b1;
      dg_out_d = (plan_q == PLAN_WORD) ? wdata_q
                                       : {8'h00, (sa0_d ? wdata_q[7:0] : wdata_q[15:8])};
    end

    if (cmd_next_c) begin
      unique case ({rw_q, is_io_q})
        2'b11:   ior_n_d  = 1'b0;
        2'b01:   iow_n_d  = 1'b0;
        2'b10:   memr_n_d = 1'b0;
        default: memw_n_d = 1'b0;
      endcase
    end
  end

  // Output registers
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      dg_out <= '0;
      dg_oe  <= 1'b0;
      sa0    <= 1'b0;
      sbhe_n <= 1'b1;
      bale_n <= 1'b1;
      ior_n  <= 1'b1;
      iow_n  <= 1'b1;
      memr_n <= 1'b1;
      memw_n <= 1'b1;
      ack    <= 1'b0;
    end else begin
      dg_out <= dg_out_d;
      dg_oe  <= dg_oe_d;
      sa0    <= sa0_d;
      sbhe_n <= sbhe_n_d;
      bale_n <= bale_n_d;
      ior_n  <= ior_n_d;
      iow_n  <= iow_n_d;
      memr_n <= memr_n_d;
      memw_n <= memw_n_d;
      ack    <= ack_d;
    end
  end

endmodule

// File: tb/tb_isa_bus_sizer.sv
// Scoreboard bench for isa_bus_sizer: expected strobe pulses and acks are queued
// by the stimulus and popped by a monitor as the DUT produces them.
module tb_isa_bus_sizer;

  localparam logic [3:0] S_IOR  = 4'b0111;
  localparam logic [3:0] S_IOW  = 4'b1011;
  localparam logic [3:0] S_MEMR = 4'b1101;
  localparam logic [3:0] S_MEMW = 4'b1110;

  typedef struct {
    logic [3:0]  which;
    logic        sa0;
    logic        sbhe_n;
    logic        oe;
    logic [15:0] dg;
    logic [15:0] mask;
    int          width;
  } pulse_t;

  typedef struct {
    int          lat;
    logic [15:0] rdata;
    logic [15:0] mask;
    logic        err;
  } ack_t;

  logic mclk, reset, req, rw, is_io, uds_n, lds_n, cs16_n, iochrdy;
  logic [15:0] wdata;
  wire  [15:0] dg_in;
  logic [15:0] dg_out, rdata;
  logic dg_oe, sa0, sbhe_n, bale_n, ior_n, iow_n, memr_n, memw_n, ack, err;

  logic [15:0] rd_even16;
  logic [7:0]  rd_odd;
  assign dg_in = sa0 ? {8'h00, rd_odd} : rd_even16;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int req_cyc = 0;
  int pulses_seen = 0;
  int acks_seen = 0;

  pulse_t pulse_q[$];
  ack_t   ack_q[$];

  isa_bus_sizer dut (
    .mclk(mclk), .reset(reset), .req(req), .rw(rw), .is_io(is_io),
    .uds_n(uds_n), .lds_n(lds_n), .wdata(wdata), .cs16_n(cs16_n),
    .iochrdy(iochrdy), .dg_in(dg_in), .dg_out(dg_out), .dg_oe(dg_oe),
    .sa0(sa0), .sbhe_n(sbhe_n), .bale_n(bale_n), .ior_n(ior_n), .iow_n(iow_n),
    .memr_n(memr_n), .memw_n(memw_n), .rdata(rdata), .ack(ack), .err(err)
  );

  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  always @(posedge mclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: one pulse record per strobe release, one ack record per ack rise
  logic       in_pulse = 1'b0;
  logic       overlap  = 1'b0;
  logic       ack_prev = 1'b0;
  int         p_start  = 0;
  pulse_t     cur;

  always @(negedge mclk) begin
    logic [3:0] s;
    pulse_t e;
    ack_t   a;
    s = {ior_n, iow_n, memr_n, memw_n};
    if (!reset) begin
      in_pulse = 1'b0;
      ack_prev = 1'b0;
    end else begin
      if (in_pulse) begin
        if (s == 4'hF) begin
          in_pulse = 1'b0;
          pulses_seen++;
          cur.width = cyc - p_start;
          if (pulse_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_pulse: strobes %b width %0d", cur.which, cur.width);
          end else begin
            e = pulse_q.pop_front();
            chk("pulse_strobe", 32'(cur.which), 32'(e.which));
            chk("pulse_sa0", 32'(cur.sa0), 32'(e.sa0));
            chk("pulse_sbhe_n", 32'(cur.sbhe_n), 32'(e.sbhe_n));
            chk("pulse_dg_oe", 32'(cur.oe), 32'(e.oe));
            chk("pulse_dg_out", 32'(cur.dg & e.mask), 32'(e.dg & e.mask));
            chk("pulse_width", 32'(cur.width), 32'(e.width));
            chk("pulse_overlap", 32'(overlap), 32'd0);
          end
        end else if ((s != cur.which) || bale_n) begin
          overlap = 1'b1;
        end
      end else if (s != 4'hF) begin
        in_pulse   = 1'b1;
        p_start    = cyc;
        cur.which  = s;
        cur.sa0    = sa0;
        cur.sbhe_n = sbhe_n;
        cur.oe     = dg_oe;
        cur.dg     = dg_out;
        overlap    = ($countones(~s) != 1) || bale_n;
      end
      if (ack && !ack_prev) begin
        acks_seen++;
        if (ack_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_ack: latency %0d", cyc - req_cyc);
        end else begin
          a = ack_q.pop_front();
          chk("ack_latency", 32'(cyc - req_cyc), 32'(a.lat));
          chk("ack_rdata", 32'(rdata & a.mask), 32'(a.rdata & a.mask));
          chk("ack_err", 32'(err), 32'(a.err));
        end
      end
      ack_prev = ack;
    end
  end

  task automatic push_pulse(input logic [3:0] which, input logic a0, input logic bhe_n,
                            input logic oe, input logic [15:0] dg, input logic [15:0] mask,
                            input int width);
    pulse_t p;
    p.which = which; p.sa0 = a0; p.sbhe_n = bhe_n; p.oe = oe;
    p.dg = dg; p.mask = mask; p.width = width;
    pulse_q.push_back(p);
  endtask

  task automatic push_ack(input int lat, input logic [15:0] rd, input logic [15:0] mask,
                          input logic e);
    ack_t a;
    a.lat = lat; a.rdata = rd; a.mask = mask; a.err = e;
    ack_q.push_back(a);
  endtask

  task automatic issue(input logic r, input logic io, input logic u, input logic l,
                       input logic c16, input logic [15:0] wd);
    @(negedge mclk);
    rw = r; is_io = io; uds_n = u; lds_n = l; cs16_n = c16; wdata = wd;
    req = 1'b1;
    req_cyc = cyc + 1;
  endtask

  task automatic finish_access(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge mclk);
      if (ack) break;
    end
    chk("ack_seen", 32'(ack), 32'd1);
    req = 1'b0;
    repeat (3) @(negedge mclk);
  endtask

  initial begin
    int base_p, base_a;
    reset = 1'b0; req = 1'b0; rw = 1'b1; is_io = 1'b0; uds_n = 1'b1; lds_n = 1'b1;
    cs16_n = 1'b1; wdata = '0; iochrdy = 1'b1; rd_even16 = '0; rd_odd = '0;
    repeat (3) @(negedge mclk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_dg_oe", 32'(dg_oe), 32'd0);
    chk("rst_dg_out", 32'(dg_out), 32'd0);
    chk("rst_sa0", 32'(sa0), 32'd0);
    chk("rst_sbhe_n", 32'(sbhe_n), 32'd1);
    chk("rst_bale_n", 32'(bale_n), 32'd1);
    chk("rst_strobes", 32'({ior_n, iow_n, memr_n, memw_n}), 32'hF);
    reset = 1'b1;
    repeat (2) @(negedge mclk);

    // 16-bit memory write
    push_pulse(S_MEMW, 1'b0, 1'b0, 1'b1, 16'hA55A, 16'hFFFF, 4);
    push_ack(9, 16'h0000, 16'h0000, 1'b0);
    issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hA55A);
    finish_access(40);

    // Word read split into two byte cycles by cs16_n = 1
    rd_even16 = 16'h0012; rd_odd = 8'h34;
    push_pulse(S_MEMR, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 4);
    push_pulse(S_MEMR, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 4);
    push_ack(17, 16'h1234, 16'hFFFF, 1'b0);
    issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    finish_access(40);

    // IO write, low byte only
    push_pulse(S_IOW, 1'b1, 1'b1, 1'b1, 16'h00C3, 16'h00FF, 4);
    push_ack(9, 16'h0000, 16'h0000, 1'b0);
    issue(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h00C3);
    finish_access(40);

    // IO read, high byte only: unused low byte reads FF
    rd_even16 = 16'h0077;
    push_pulse(S_IOR, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 4);
    push_ack(9, 16'h77FF, 16'hFFFF, 1'b0);
    issue(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000);
    finish_access(40);

    // 16-bit read with iochrdy low for 10 sampled cycles
    rd_even16 = 16'hBEEF;
    push_pulse(S_MEMR, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 14);
    push_ack(19, 16'hBEEF, 16'hFFFF, 1'b0);
    issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    iochrdy = 1'b0;
    repeat (16) @(negedge mclk);
    iochrdy = 1'b1;
    finish_access(40);

    // iochrdy stuck low: forced termination after the timeout
    rd_even16 = 16'h5AC3;
    push_pulse(S_MEMR, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 68);
    push_ack(73, 16'h5AC3, 16'hFFFF, 1'b1);
    issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    iochrdy = 1'b0;
    finish_access(120);
    iochrdy = 1'b1;

    // Reset during CMD of the first byte of a pair
    issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234);
    for (int i = 0; i < 20; i++) begin
      @(negedge mclk);
      if (!memw_n) break;
    end
    chk("pair_cmd_reached", 32'(memw_n), 32'd0);
    @(negedge mclk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_strobes", 32'({ior_n, iow_n, memr_n, memw_n}), 32'hF);
    chk("midrst_dg_oe", 32'(dg_oe), 32'd0);
    chk("midrst_bale_n", 32'(bale_n), 32'd1);
    req = 1'b0;
    repeat (3) @(negedge mclk);
    reset = 1'b1;
    repeat (2) @(negedge mclk);
    push_pulse(S_MEMW, 1'b0, 1'b1, 1'b1, 16'h0012, 16'h00FF, 4);
    push_pulse(S_MEMW, 1'b1, 1'b1, 1'b1, 16'h0034, 16'h00FF, 4);
    push_ack(17, 16'h0000, 16'h0000, 1'b0);
    issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234);
    finish_access(40);

    // req dropped during the first byte of a pair
    base_p = pulses_seen;
    base_a = acks_seen;
    rd_even16 = 16'h0056; rd_odd = 8'h78;
    push_pulse(S_MEMR, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 4);
    issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    repeat (4) @(negedge mclk);
    req = 1'b0;
    repeat (25) @(negedge mclk);
    chk("drop_pulse_count", 32'(pulses_seen - base_p), 32'd1);
    chk("drop_ack_count", 32'(acks_seen - base_a), 32'd0);
    chk("drop_idle_bale_n", 32'(bale_n), 32'd1);
    chk("drop_idle_ack", 32'(ack), 32'd0);

    chk("pulse_q_drained", 32'(pulse_q.size()), 32'd0);
    chk("ack_q_drained", 32'(ack_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/isa_bus_sizer.md
# isa_bus_sizer

ISA-side cycle sequencer. It sits directly downstream of the Zorro II address decoder / wait-state block. It takes one decoded Amiga access (request level, direction, IO/mem, data strobes, write data) and runs one or two 8/16-bit ISA cycles on the VGA chip's bus. It returns assembled read data and an acknowledge that the decoder uses to release XRDY. It replaces the fixed strobe timing with CS16-driven bus sizing, IOCHRDY wait handling and a ready timeout.

## Interface
Parameters:
- ADDR_CYCLES, 2, mclk cycles of address setup (bale_n low, strobes high) before a command strobe
- CMD_CYCLES, 4, minimum mclk cycles a command strobe is held low
- RECOVERY, 2, mclk cycles all strobes high after a command, before the next ISA cycle or ack
- TIMEOUT, 64, maximum mclk cycles spent waiting for iochrdy before forced termination

Ports:
- mclk  in  1  VGA clock (~28 MHz); all state on rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  1  level request from decoder; held high until the Amiga cycle ends
- rw  in  1  1 = read, 0 = write; sampled with req
- is_io  in  1  1 = IO cycle (IOR/IOW), 0 = memory cycle (MEMR/MEMW)
- uds_n, lds_n  in  1 each  Amiga data strobes, sampled when ADDR ends
- wdata  in  16  Amiga write data, captured when ADDR ends
- cs16_n  in  1  VGA MEMCS16/IOCS16, sampled on the last ADDR cycle
- iochrdy  in  1  VGA ready (WAIT); 0 extends the command
- dg_in  in  16  ISA data bus read value
- dg_out  out  16  ISA data bus drive value
- dg_oe  out  1  ISA data bus output enable
- sa0  out  1  ISA address bit 0
- sbhe_n  out  1  ISA byte-high enable
- bale_n  out  1  address latch phase marker, low from ADDR entry to RECOVERY entry
- ior_n, iow_n, memr_n, memw_n  out  1 each  ISA command strobes
- rdata  out  16  assembled read data, valid while ack = 1
- ack  out  1  access complete; high from DONE until req falls
- err  out  1  sticky per access: a timeout occurred; cleared on next req

## Operation
- States: IDLE, ADDR, CMD, WAITRDY, RECOV, DONE. A counter is loaded on each state entry.
- IDLE: req sampled high → clear err, latch rw/is_io → ADDR.
- ADDR: bale_n = 0, sa0/sbhe_n driven for the current phase. On the last cycle, sample uds_n, lds_n and cs16_n (first phase only) and choose the plan:
  - both strobes low and cs16_n = 0 → one 16-bit cycle: sa0 = 0, sbhe_n = 0, dg = wdata/rdata straight
  - both strobes low and cs16_n = 1 → two byte cycles on dg[7:0]:
    - even byte: sa0 = 0, wdata[15:8] / rdata[15:8]
    - odd byte: sa0 = 1, wdata[7:0] / rdata[7:0]
  - single strobe → one byte cycle on dg[7:0], sa0 = uds_n, sbhe_n = 1; the unused rdata byte reads 8'hFF
- Write: dg_oe = 1 from ADDR exit through RECOV end.
- CMD: the one selected strobe goes low for CMD_CYCLES. It then goes to WAITRDY if iochrdy = 0, else to RECOV.
- WAITRDY: stays until iochrdy = 1 → RECOV. If TIMEOUT cycles elapse first, set err = 1 → RECOV.
- Read data is captured from dg_in on the cycle the strobe is released.
- RECOV: all strobes high, bale_n = 1. Then:
  - if a second byte is pending and req = 1 → ADDR (second phase, cs16_n not resampled)
  - otherwise, if req = 1 → DONE
  - otherwise → IDLE
- DONE: ack = 1 until req = 0 → IDLE.
- Early req drop: the active ISA cycle always completes, any pending second byte is skipped, no ack.
- req edge exactly at the RECOV→DONE boundary: req = 0 sampled on that edge → IDLE.

## Timing
- Reset values: ack 0, err 0, rdata 0, dg_oe 0, dg_out 0, sa0 0, sbhe_n 1, bale_n 1, all command strobes 1. State = IDLE.
- Reset mid-cycle forces these values immediately (async) and abandons the access.
- Latency with iochrdy = 1 throughout, from the edge req is first sampled high:
  - single cycle: ack rises after ADDR_CYCLES + CMD_CYCLES + RECOVERY + 1 = 9 cycles
  - byte pair: ack rises after 2*(ADDR_CYCLES + CMD_CYCLES + RECOVERY) + 1 = 17 cycles
- Each iochrdy-low cycle in WAITRDY adds one cycle. iochrdy is only sampled in CMD (last cycle) and WAITRDY.
- No two command strobes are ever low simultaneously. A strobe never overlaps bale_n = 1.

## Structure
- Shared package isa_sizer_pkg holds:
  - the state enum
  - plan encodings (WORD, BYTE_PAIR, BYTE_SINGLE)
  - the default parameter constants
- One sub-module, isa_phase_counter: loadable down-counter with a terminal flag, shared by the ADDR/CMD/WAITRDY/RECOV phases.

## Test plan
- 16-bit mem write, uds_n = lds_n = 0, cs16_n = 0, wdata = 16'hA55A:
  - memw_n low 4 cycles, sbhe_n = 0, dg_out = 16'hA55A
  - ack at cycle 9
- 16-bit mem read, cs16_n = 1, VGA returns 8'h12 then 8'h34:
  - two memr_n pulses, sa0 0 then 1
  - rdata = 16'h1234, ack at cycle 17
- IO write, lds_n only, wdata = 16'h00C3:
  - one iow_n pulse, sa0 = 1, sbhe_n = 1, dg_out[7:0] = 8'hC3
- 16-bit read with iochrdy low for 10 cycles after CMD:
  - strobe held 14 cycles, ack at cycle 19, err = 0
- iochrdy stuck low:
  - strobe released after CMD_CYCLES + 64 cycles, err = 1, ack asserted, rdata = captured dg_in
- Reset pulse during CMD of the first byte of a pair:
  - all strobes high and dg_oe = 0 within the reset
  - next req runs a clean cycle
- req dropped during the first byte of a pair:
  - first byte completes, no second ADDR, no ack, returns to IDLE
